// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the data-memory access path: instruction IDs,
// exception codes and the access-unit state encoding.
package mem_access_unit_pkg;

   localparam logic [10:0] ID_LB  = 11'h020;
   localparam logic [10:0] ID_LH  = 11'h021;
   localparam logic [10:0] ID_LW  = 11'h023;
   localparam logic [10:0] ID_LBU = 11'h024;
   localparam logic [10:0] ID_LHU = 11'h025;
   localparam logic [10:0] ID_SB  = 11'h028;
   localparam logic [10:0] ID_SH  = 11'h029;
   localparam logic [10:0] ID_SW  = 11'h02b;

   localparam logic [4:0] EXC_NONE = 5'd0;
   localparam logic [4:0] EXC_ADEL = 5'd4;
   localparam logic [4:0] EXC_ADES = 5'd5;
   localparam logic [4:0] EXC_DBE  = 5'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_DONE = 2'd2
   } mauState_t;

   function automatic logic isLoad(input logic [10:0] id);
      return (id == ID_LB) || (id == ID_LH) || (id == ID_LW) ||
             (id == ID_LBU) || (id == ID_LHU);
   endfunction

   function automatic logic isStore(input logic [10:0] id);
      return (id == ID_SB) || (id == ID_SH) || (id == ID_SW);
   endfunction

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Selects the addressed byte/half of a read word and sign- or zero-extends
// it according to the load instruction. Non-load IDs yield zero.
module mem_access_unit_load_extender
   import mem_access_unit_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [10:0] instrId,
   output logic [31:0] result
);

   logic [7:0]  byteSel;
   logic [15:0] halfSel;

   // pick the addressed lane, then extend per instruction
   always_comb begin
      byteSel = word[{offset, 3'b000} +: 8];
      halfSel = offset[1] ? word[31:16] : word[15:0];
      case (instrId)
         ID_LB:   result = {{24{byteSel[7]}}, byteSel};
         ID_LBU:  result = {24'h000000, byteSel};
         ID_LH:   result = {{16{halfSel[15]}}, halfSel};
         ID_LHU:  result = {16'h0000, halfSel};
         ID_LW:   result = word;
         default: result = 32'h00000000;
      endcase
   end

endmodule

// File: rtl/mem_access_unit.sv
// M-stage data-memory bus initiator: alignment/range checks, req/ack
// transaction with timeout, pipeline stall and load-result extension.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; faults reported combinationally
// WAIT    | bus_req held, waiting for bus_ack or timeout
// DONE    | one cycle: load_data / DBE presented, pipeline advances
module mem_access_unit
   import mem_access_unit_pkg::*;
#(
   parameter logic [31:0] DM_TOP  = 32'h00002fff,
   parameter int          TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic [10:0] instr_id,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic        int_req,
   output logic        stall,
   output logic [31:0] load_data,
   output logic [4:0]  exc_code,
   output logic        bus_req,
   output logic        bus_we,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   mauState_t   state;
   logic [4:0]  timeoutCnt;
   logic [10:0] idQ;
   logic [1:0]  offsetQ;
   logic [31:0] rdataQ;
   logic        dbeFlag;

   logic        ld, st, memOp, alignFault, rangeFault, fault, start;
   logic [3:0]  beNext;
   logic [31:0] wdataNext;
   logic [31:0] extResult;

   // decode the request and its address faults
   always_comb begin
      ld         = isLoad(instr_id);
      st         = isStore(instr_id);
      memOp      = req_valid & (ld | st);
      alignFault = (((instr_id == ID_LW) || (instr_id == ID_SW)) && (addr[1:0] != 2'b00)) ||
                   (((instr_id == ID_LH) || (instr_id == ID_LHU) || (instr_id == ID_SH)) && addr[0]);
      rangeFault = addr > DM_TOP;
      fault      = alignFault | rangeFault;
      start      = (state == ST_IDLE) & memOp & ~fault & ~int_req;
   end

   // byte enables and lane-replicated store data for the issuing access
   always_comb begin
      beNext    = 4'b1111;
      wdataNext = wdata;
      case (instr_id)
         ID_SB: begin
            beNext    = 4'b0001 << addr[1:0];
            wdataNext = {4{wdata[7:0]}};
         end
         ID_SH: begin
            beNext    = addr[1] ? 4'b1100 : 4'b0011;
            wdataNext = {2{wdata[15:0]}};
         end
         default: ;
      endcase
   end

   // stall and exception outputs; gated by reset so they drop at once
   always_comb begin
      stall    = ~reset & (start | (state == ST_WAIT));
      exc_code = EXC_NONE;
      if (!reset) begin
         if ((state == ST_IDLE) && memOp && fault)
            exc_code = st ? EXC_ADES : EXC_ADEL;
         else if ((state == ST_DONE) && dbeFlag)
            exc_code = EXC_DBE;
      end
   end

   mem_access_unit_load_extender u_ext (
      .word    (rdataQ),
      .offset  (offsetQ),
      .instrId (idQ),
      .result  (extResult)
   );

   // load result is only presented in DONE, and forced to zero on a bus error
   always_comb begin
      load_data = ((state == ST_DONE) && !dbeFlag) ? extResult : 32'h00000000;
   end

   // transaction FSM with registered bus outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         timeoutCnt <= 5'd0;
         bus_req    <= 1'b0;
         bus_we     <= 1'b0;
         bus_be     <= 4'b0000;
         bus_addr   <= 32'h00000000;
         bus_wdata  <= 32'h00000000;
         idQ        <= 11'd0;
         offsetQ    <= 2'b00;
         rdataQ     <= 32'h00000000;
         dbeFlag    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state      <= ST_WAIT;
                  bus_req    <= 1'b1;
                  bus_we     <= st;
                  bus_be     <= beNext;
                  bus_addr   <= {addr[31:2], 2'b00};
                  bus_wdata  <= wdataNext;
                  idQ        <= instr_id;
                  offsetQ    <= addr[1:0];
                  timeoutCnt <= 5'd0;
                  dbeFlag    <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (bus_ack) begin
                  rdataQ  <= bus_rdata;
                  bus_req <= 1'b0;
                  state   <= ST_DONE;
               end else if (timeoutCnt == 5'(TIMEOUT - 1)) begin
                  bus_req <= 1'b0;
                  dbeFlag <= 1'b1;
                  state   <= ST_DONE;
               end else if (timeoutCnt != 5'h1f) begin
                  timeoutCnt <= timeoutCnt + 5'd1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
CPU-side initiator for the data-memory bus. It is the M-stage counterpart to the word-addressed data memory. It takes the M-stage memory instruction, checks alignment and range, and drives a req/ack bus with a word address, byte enables and lane-replicated write data. While a transaction is outstanding it stalls the pipeline. For loads it returns the sign- or zero-extended result.

Parameters:
DM_TOP, 32'h00002fff, highest legal byte address; any access above it raises an address exception.
TIMEOUT, 16, maximum WAIT cycles without bus_ack before a bus error is raised.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
req_valid  in  1  M-stage holds a valid instruction
instr_id  in  11  instruction ID, using the shared instruction-ID constants (lw/lh/lhu/lb/lbu/sw/sh/sb)
addr  in  32  effective byte address
wdata  in  32  store data (rt value)
int_req  in  1  interrupt taken this cycle; cancels a not-yet-issued access
stall  out  1  freeze F..M stages
load_data  out  32  extended load result, valid in DONE
exc_code  out  5  0 none, 4 AdEL, 5 AdES, 7 DBE
bus_req  out  1  transaction request, held until ack or timeout
bus_we  out  1  1 = write
bus_be  out  4  byte enables
bus_addr  out  32  {addr[31:2],2'b00}
bus_wdata  out  32  lane-replicated store data
bus_ack  in  1  responder completion, one-cycle pulse
bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Reset values: all outputs 0. State IDLE. Timeout counter 0. Reset is asynchronous; asserting it mid-transaction drops bus_req and stall immediately.
- mem_op = req_valid & instr_id is one of the eight load/store IDs.
- Alignment fault: lw/sw with addr[1:0]!=0, or lh/lhu/sh with addr[0]!=0.
- Range fault: addr > DM_TOP.
- A fault on a load gives AdEL (4); a fault on a store gives AdES (5).
- Faults are combinational in IDLE: exc_code is set, stall=0, and no transaction is issued.
- start = IDLE & mem_op & no fault & !int_req.
- stall = start | (state==WAIT). It is combinational, so the pipeline is frozen from the first cycle.
- IDLE -> WAIT on start. At that edge the unit registers:
  - bus_addr
  - bus_we (1 for stores)
  - bus_be: sb gives 1<<addr[1:0]; sh gives addr[1]?4'b1100:4'b0011; sw and all loads give 4'b1111
  - bus_wdata: sb gives {4{wdata[7:0]}}, sh gives {2{wdata[15:0]}}, sw gives wdata
  - instr_id and addr[1:0], latched for later extension
  - bus_req=1
- WAIT: bus_req, bus_we, bus_be, bus_addr and bus_wdata stay constant.
  - On bus_ack: capture bus_rdata, drop bus_req, go to DONE.
  - Otherwise increment the counter. When it reaches TIMEOUT-1 without ack: drop bus_req, go to DONE with the DBE flag set.
- DONE (one cycle), then unconditionally back to IDLE:
  - stall=0.
  - load_data is valid: the selected byte/half is sign-extended (lb/lh) or zero-extended (lbu/lhu); lw passes the whole word.
  - exc_code=7 if DBE, and load_data=0 in that case.
  - The pipeline advances at the end of DONE, so the same instruction is never reissued.
- int_req in IDLE suppresses the access entirely; this matters for stores, which must not commit.
- int_req during WAIT does not abort the bus: the transaction completes, and the epilogue is the exception handler's concern.
- bus_ack while in IDLE or DONE is ignored.
- Timeout counter is 5 bits and saturates; it clears on entering WAIT.

Decomposition:
- Shared header (the existing instruction-ID include): instruction-ID constants, exception codes EXC_ADEL=4, EXC_ADES=5, EXC_DBE=7, state encodings.
- One sub-module: load_extender. It is combinational: (word, latched addr[1:0], latched instr_id) -> 32-bit result. It is reused by the bridge for peripheral reads.

Test Plan:
- sw addr=0x10, wdata=0xDEADBEEF, ack 2 cycles after req -> bus_addr=0x10, be=4'b1111, we=1, stall high for 3 cycles, DONE one cycle, exc_code=0.
- lb addr=0x23, bus_rdata=0x80112233 -> be=4'b1111, load_data=0xFFFFFF80; lbu same -> 0x00000080; lhu addr=0x22 -> 0x00008011.
- sh addr=0x31 -> exc_code=5 same cycle, bus_req never asserts, stall=0; lw addr=0x3000 -> exc_code=4.
- sb addr=0x5, wdata=0xAB, int_req=1 -> no bus_req; repeat with int_req=0 -> be=4'b0010, bus_wdata=0xABABABAB.
- lw with no ack -> bus_req held for exactly TIMEOUT cycles, then DONE with exc_code=7, load_data=0, stall releases.
- reset asserted mid-WAIT -> bus_req, stall, exc_code 0 immediately; the next lw starts cleanly from IDLE.
